float_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `float_add` core among `NREQ` requesters. It accepts operand pairs over a valid/ready handshake and restarts the core for each operation. It holds the operands stable for the core's fixed latency, then returns the sum and overflow code tagged with the requester index. It sits between the requesting pipelines and the single `float_add` instance.

---
 rtl/float_add_arbiter.sv | 104 ++++++++++
 tb/tb_float_add_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/float_add_arbiter.sv
// float_add_arbiter: round-robin sequencer sharing one float_add core among NREQ requesters
module float_add_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 50,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_z,
    output logic [1:0]           rsp_overflow,
    output logic                 busy,
    output logic                 fa_rst,
    output logic [31:0]          fa_x,
    output logic [31:0]          fa_y,
    input  logic [31:0]          fa_z,
    input  logic [1:0]           fa_overflow
);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]     r_state;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] r_cur;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_x;
    logic [31:0]    r_y;
    logic [31:0]    r_z;
    logic [1:0]     r_ovf;
    logic [IDW-1:0] w_gid;
    logic [IDW-1:0] w_idx;
    logic           w_found;
    logic           w_acc;

    // Round-robin search: scan from farthest to nearest after r_last so the nearest valid index wins
    always_comb begin
        w_gid   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IDW'((int'(r_last) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_gid   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign req_ready    = (r_state == S_IDLE && w_found && !rst) ? (NREQ'(1) << w_gid) : '0;
    assign w_acc        = |(req_valid & req_ready);
    assign busy         = r_state != S_IDLE;
    assign fa_rst       = !(rst || r_state == S_ISSUE);
    assign fa_x         = r_x;
    assign fa_y         = r_y;
    assign rsp_valid    = r_state == S_RESP;
    assign rsp_id       = r_cur;
    assign rsp_z        = r_z;
    assign rsp_overflow = r_ovf;

    // Sequencer: accept, pulse the core restart, wait out the core latency, hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= IDW'(NREQ - 1);
            r_cur   <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_ovf   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_acc) begin
                    r_x     <= req_x[{w_gid, 5'b0} +: 32];
                    r_y     <= req_y[{w_gid, 5'b0} +: 32];
                    r_cur   <= w_gid;
                    r_last  <= w_gid;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (r_cnt == CW'(LATENCY - 1)) begin
                    r_z     <= fa_z;
                    r_ovf   <= fa_overflow;
                    r_state <= S_RESP;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: if (rsp_ready) r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_add_arbiter.sv
// tb_float_add_arbiter: directed and random checks of the shared float_add sequencer
module tb_float_add_arbiter;
    localparam int NREQ    = 4;
    localparam int LATENCY = 50;
    localparam int IDW     = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_x = '0;
    logic [32*NREQ-1:0]  req_y = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_z;
    logic [1:0]          rsp_overflow;
    logic                busy;
    logic                fa_rst;
    logic [31:0]         fa_x;
    logic [31:0]         fa_y;
    logic [31:0]         fa_z;
    logic [1:0]          fa_overflow;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_last = NREQ - 1;
    int n_acc = 0;
    int n_pulse = 0;
    int core_k = 0;
    logic [31:0] bx [NREQ];
    logic [31:0] by [NREQ];
    logic [33:0] core_w;
    logic        prev_busy = 1'b0;
    logic        prev_low = 1'b0;
    logic [31:0] prev_fx = '0;
    logic [31:0] prev_fy = '0;

    float_add_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_z(rsp_z), .rsp_overflow(rsp_overflow), .busy(busy),
        .fa_rst(fa_rst), .fa_x(fa_x), .fa_y(fa_y), .fa_z(fa_z), .fa_overflow(fa_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: known IEEE vectors from the plan, otherwise an arbitrary mix; result as {ovf, z}
    function automatic logic [33:0] core_fn(input logic [31:0] x, input logic [31:0] y);
        case ({x, y})
            {32'h3F47AE14, 32'h3F0CCCCD}: return {2'b00, 32'h3FAA3D70};
            {32'h42C80000, 32'h43480000}: return {2'b00, 32'h43960000};
            {32'h7F7FFFFF, 32'h7F7FFFFF}: return {2'b01, 32'h7F800000};
            {32'hFF800000, 32'h7F800000}: return {2'b00, 32'h7FFFFFFF};
            {32'hBF000000, 32'h3F99999A}: return {2'b00, 32'h3F333334};
            default:                      return {x[1:0] ^ y[1:0], x + y};
        endcase
    endfunction

    // Core output is garbage (inverted) until LATENCY cycles after restart release
    always @(posedge clk) core_k <= !fa_rst ? 0 : core_k + 1;
    always_comb begin
        core_w      = core_fn(fa_x, fa_y);
        fa_z        = (core_k >= LATENCY - 1) ? core_w[31:0]  : ~core_w[31:0];
        fa_overflow = (core_k >= LATENCY - 1) ? core_w[33:32] : ~core_w[33:32];
    end

    function automatic int rr(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Continuous checks: one-cycle restart pulse, operands frozen while busy
    always @(negedge clk) begin
        if (|(req_valid & req_ready)) n_acc++;
        if (!rst && !fa_rst) begin
            n_pulse++;
            n_chk++;
            assert (!prev_low) else begin
                n_fail++;
                $error("FAIL restart_pulse: fa_rst low two cycles in a row, observed 0 expected 1");
            end
        end
        if (busy && prev_busy) begin
            n_chk++;
            assert ({fa_x, fa_y} === {prev_fx, prev_fy}) else begin
                n_fail++;
                $error("FAIL operand_hold: observed %h_%h expected %h_%h", fa_x, fa_y, prev_fx, prev_fy);
            end
        end
        prev_low  <= !rst && !fa_rst;
        prev_busy <= busy;
        prev_fx   <= fa_x;
        prev_fy   <= fa_y;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y);
        bx[i] = x;
        by[i] = y;
        req_x[32*i +: 32] = x;
        req_y[32*i +: 32] = y;
        req_valid[i] = 1'b1;
    endtask

    // One full operation: expected grant, restart/operands, latency, response, optional backpressure
    task automatic do_op(input int exp_id, input int bp);
        int t;
        int a;
        logic [33:0] e;
        @(negedge clk);
        t = 0;
        while (!(|(req_valid & req_ready)) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("grant_timeout", 32'(t < 200), 32'd1);
        check("grant", 32'(req_ready), 32'(1) << exp_id);
        a = cyc;
        m_last = exp_id;
        e = core_fn(bx[exp_id], by[exp_id]);
        @(posedge clk);
        #1 req_valid[exp_id] = 1'b0;
        @(negedge clk);
        check("issue_fa_rst", 32'(fa_rst), 32'd0);
        check("issue_fa_x", fa_x, bx[exp_id]);
        check("issue_fa_y", fa_y, by[exp_id]);
        t = 0;
        while (!rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rsp_latency", 32'(cyc - a), 32'(LATENCY + 2));
        check("rsp_id", 32'(rsp_id), 32'(exp_id));
        check("rsp_z", rsp_z, e[31:0]);
        check("rsp_overflow", 32'(rsp_overflow), 32'(e[33:32]));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid_id_ovf", 32'({rsp_valid, rsp_id, rsp_overflow}), 32'({1'b1, IDW'(exp_id), e[33:32]}));
            check("bp_z", rsp_z, e[31:0]);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int a;
        int g;
        logic [NREQ-1:0] mask;
        // reset state, with a request already pending
        set_req(0, 32'h3F47AE14, 32'h3F0CCCCD);
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_fa_rst", 32'(fa_rst), 32'd0);
        check("rst_busy_valid", 32'({busy, rsp_valid}), 32'd0);
        check("rst_rsp", 32'({rsp_id, rsp_overflow}), 32'd0);
        check("rst_rsp_z", rsp_z, 32'd0);
        check("rst_fa_xy", fa_x | fa_y, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        // single request
        do_op(0, 0);
        // contention from a fresh reset
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_last = NREQ - 1;
        set_req(0, 32'h3F47AE14, 32'h3F0CCCCD);
        set_req(1, 32'h42C80000, 32'h43480000);
        set_req(2, 32'h7F7FFFFF, 32'h7F7FFFFF);
        set_req(3, 32'hFF800000, 32'h7F800000);
        do_op(0, 0);
        do_op(1, 0);
        do_op(2, 0);
        set_req(0, 32'h3F47AE14, 32'h3F0CCCCD);
        set_req(2, 32'h12345678, 32'h0ABCDEF0);
        do_op(3, 0);
        do_op(0, 0);
        do_op(2, 0);
        // backpressure with req1 waiting
        set_req(3, $urandom, $urandom);
        set_req(1, $urandom, $urandom);
        do_op(3, 10);
        check("bp_regrant", 32'(req_ready), 32'd2);
        do_op(1, 0);
        // reset in the middle of WAIT
        set_req(3, 32'hBF000000, 32'h3F99999A);
        @(negedge clk);
        g = 0;
        while (!(|(req_valid & req_ready)) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("midrst_grant", 32'(req_ready), 32'd8);
        a = cyc;
        while (cyc < a + 22) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_fa_rst", 32'(fa_rst), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_busy_valid", 32'({busy, rsp_valid}), 32'd0);
        check("midrst_fa_xy", fa_x | fa_y, 32'd0);
        check("midrst_rsp_z", rsp_z, 32'd0);
        rst = 1'b0;
        m_last = NREQ - 1;
        do_op(3, 0);
        // random traffic against the round-robin model
        for (int it = 0; it < 20; it++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) if (mask[i] && !req_valid[i]) set_req(i, $urandom, $urandom);
            g = rr(req_valid, m_last);
            do_op(g, $urandom_range(0, 3));
        end
        while (|req_valid) do_op(rr(req_valid, m_last), 0);
        check("pulse_count", 32'(n_pulse), 32'(n_acc));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
